// File: rtl/kalman_pkg.sv
// Kalman sequencer shared definitions.
// State codes and the phase-to-go mapping.
package kalman_pkg;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_PRED_STATE = 3'd1;
  localparam logic [2:0] S_PRED_COV   = 3'd2;
  localparam logic [2:0] S_GAIN       = 3'd3;
  localparam logic [2:0] S_UPD_STATE  = 3'd4;
  localparam logic [2:0] S_UPD_COV    = 3'd5;
  localparam logic [2:0] S_DONE       = 3'd6;
  localparam logic [2:0] S_ERROR      = 3'd7;

  typedef struct packed {
    logic upd_cov;
    logic upd_state;
    logic gain;
    logic pred_cov;
    logic pred_state;
  } go_t;

  function automatic logic is_phase(
    input logic [2:0] s
  );
    return (s >= S_PRED_STATE) &&
           (s <= S_UPD_COV);
  endfunction

  function automatic go_t phase_go(
    input logic [2:0] s
  );
    go_t g;
    g = '0;
    unique case (1'b1)
      (s == S_PRED_STATE): g.pred_state = 1'b1;
      (s == S_PRED_COV):   g.pred_cov   = 1'b1;
      (s == S_GAIN):       g.gain       = 1'b1;
      (s == S_UPD_STATE):  g.upd_state  = 1'b1;
      (s == S_UPD_COV):    g.upd_cov    = 1'b1;
      default:             g            = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/kalman_seq_if.sv
// Go/done strobes between the sequencer
// and the Kalman arithmetic units.
interface kalman_seq_if;

  logic pred_state_go;
  logic pred_cov_go;
  logic gain_go;
  logic upd_state_go;
  logic upd_cov_go;

  logic pred_state_done;
  logic pred_cov_done;
  logic inv_done;
  logic gain_done;
  logic upd_state_done;
  logic upd_cov_done;

  modport master (
    output pred_state_go, pred_cov_go,
    output gain_go,
    output upd_state_go, upd_cov_go,
    input  pred_state_done, pred_cov_done,
    input  inv_done, gain_done,
    input  upd_state_done, upd_cov_done
  );

  modport slave (
    input  pred_state_go, pred_cov_go,
    input  gain_go,
    input  upd_state_go, upd_cov_go,
    output pred_state_done, pred_cov_done,
    output inv_done, gain_done,
    output upd_state_done, upd_cov_done
  );

endinterface

// File: rtl/kalman_phase_tmr.sv
// Per-phase watchdog: counts cycles spent
// in the current phase, flags expiry.
module kalman_phase_tmr #(
  parameter int TMO_W   = 10,
  parameter int TMO_CYC = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMO_W-1:0] LIMIT =
    TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  // cnt holds cycles already spent, so the
  // TMO_CYC-th cycle in a phase is the last
  assign expired = en && (cnt == LIMIT);

endmodule

// File: rtl/kalman_seq.sv
// Multi-iteration Kalman step sequencer
// driving predict, gain and update units.
module kalman_seq #(
  parameter int N_ITER_W = 8,
  parameter int TMO_W    = 10,
  parameter int TMO_CYC  = 1000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [N_ITER_W-1:0] n_iter,
  input  logic                upd_only,
  input  logic                meas_valid,
  input  logic                abort,
  input  logic                clear,
  kalman_seq_if.master        units,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [2:0]          err_phase,
  output logic [N_ITER_W-1:0] iter_cnt,
  output logic [2:0]          state
);

  import kalman_pkg::*;

  logic [2:0]          nxt;
  logic [2:0]          first_ph;
  logic [N_ITER_W-1:0] n_lat;
  logic [N_ITER_W-1:0] cnt_inc;
  logic                upd_lat;
  logic                inv_seen;
  logic                gain_seen;
  logic                gain_ok;
  logic                adv;
  logic                iter_end;
  logic                tmo;
  logic                ph_chg;
  logic                in_phase;
  go_t                 go_q;

  assign cnt_inc  = iter_cnt + N_ITER_W'(1);
  assign first_ph = upd_lat ? S_GAIN
                            : S_PRED_STATE;
  assign gain_ok  =
    (inv_seen  || units.inv_done) &&
    (gain_seen || units.gain_done);
  assign ph_chg   = (nxt != state);
  assign in_phase = is_phase(state);

  always_comb begin
    nxt      = state;
    adv      = 1'b0;
    iter_end = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && (n_iter != '0))
          nxt = upd_only ? S_GAIN
                         : S_PRED_STATE;
      end
      S_PRED_STATE: begin
        if (units.pred_state_done) begin
          adv = 1'b1;
          nxt = S_PRED_COV;
        end
      end
      S_PRED_COV: begin
        if (units.pred_cov_done) begin
          adv = 1'b1;
          if (meas_valid || upd_lat)
            nxt = S_GAIN;
          else
            iter_end = 1'b1;
        end
      end
      S_GAIN: begin
        if (gain_ok) begin
          adv = 1'b1;
          nxt = S_UPD_STATE;
        end
      end
      S_UPD_STATE: begin
        if (units.upd_state_done) begin
          adv = 1'b1;
          nxt = S_UPD_COV;
        end
      end
      S_UPD_COV: begin
        if (units.upd_cov_done) begin
          adv      = 1'b1;
          iter_end = 1'b1;
        end
      end
      S_DONE:  nxt = S_IDLE;
      S_ERROR: if (clear) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (iter_end)
      nxt = (cnt_inc == n_lat) ? S_DONE
                               : first_ph;
    // abort outranks a same-cycle done
    if (in_phase) begin
      if (abort) begin
        nxt      = S_IDLE;
        iter_end = 1'b0;
      end else if (!adv && tmo) begin
        nxt = S_ERROR;
      end
    end
  end

  kalman_phase_tmr #(
    .TMO_W   (TMO_W),
    .TMO_CYC (TMO_CYC)
  ) u_tmr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (ph_chg),
    .en      (in_phase),
    .expired (tmo)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_phase <= '0;
      iter_cnt  <= '0;
      n_lat     <= '0;
      upd_lat   <= 1'b0;
      inv_seen  <= 1'b0;
      gain_seen <= 1'b0;
      go_q      <= '0;
    end else begin
      state <= nxt;
      busy  <= is_phase(nxt);
      done  <= (nxt == S_DONE);
      error <= (nxt == S_ERROR);
      go_q  <= ph_chg ? phase_go(nxt) : '0;
      if ((state == S_IDLE) && ph_chg) begin
        n_lat    <= n_iter;
        upd_lat  <= upd_only;
        iter_cnt <= '0;
      end
      if (iter_end)
        iter_cnt <= cnt_inc;
      if ((nxt == S_ERROR) && in_phase)
        err_phase <= state;
      if ((nxt == S_GAIN) && ph_chg) begin
        inv_seen  <= 1'b0;
        gain_seen <= 1'b0;
      end else if (state == S_GAIN) begin
        inv_seen  <= inv_seen  | units.inv_done;
        gain_seen <= gain_seen | units.gain_done;
      end
    end
  end

  assign units.pred_state_go = go_q.pred_state;
  assign units.pred_cov_go   = go_q.pred_cov;
  assign units.gain_go       = go_q.gain;
  assign units.upd_state_go  = go_q.upd_state;
  assign units.upd_cov_go    = go_q.upd_cov;

endmodule
